// File: rtl/mems_onchip_write_arbiter.sv
// Round-robin arbiter with a bounded burst lock. It shares one Avalon-MM write master
// into on-chip memory among NUM_REQ requesters and aborts a write after a waitrequest timeout.
module mems_onchip_write_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_BEATS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic [ADDR_WIDTH-1:0]         address,
  output logic                          write,
  output logic [DATA_WIDTH-1:0]         write_data,
  input  logic                          waitrequest,
  output logic [31:0]                   write_count,
  output logic                          timeout_err
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_t;

  state_t          state_r;
  logic [IW-1:0]   rr_ptr_r;
  logic [IW-1:0]   owner_r;
  logic [BW-1:0]   beat_cnt_r;
  logic [WW-1:0]   wait_cnt_r;

  logic            lock_s;
  logic            rr_hit_s;
  logic [IW-1:0]   rr_idx_s;
  logic            sel_valid_s;
  logic [IW-1:0]   sel_idx_s;

  function automatic logic [IW-1:0] slot_add(input logic [IW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return IW'(s);
  endfunction

  // Requester selection: keep the previous owner while locked, else first valid from rr_ptr_r
  always_comb begin
    lock_s      = 1'b0;
    rr_hit_s    = 1'b0;
    rr_idx_s    = '0;
    sel_valid_s = 1'b0;
    sel_idx_s   = '0;
    // beat_cnt_r == 0 only after reset, when there is no previous owner to lock onto
    if ((beat_cnt_r != '0) && (beat_cnt_r < BW'(MAX_BEATS)) && req_valid[owner_r]) begin
      lock_s = 1'b1;
    end else begin
      lock_s = 1'b0;
    end
    // Scan downward so the slot closest to rr_ptr_r is the last one written and wins
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[slot_add(rr_ptr_r, k)]) begin
        rr_hit_s = 1'b1;
        rr_idx_s = slot_add(rr_ptr_r, k);
      end else begin
        rr_hit_s = rr_hit_s;
        rr_idx_s = rr_idx_s;
      end
    end
    sel_valid_s = lock_s | rr_hit_s;
    sel_idx_s   = lock_s ? owner_r : rr_idx_s;
  end

  // Transaction FSM with registered Avalon outputs, acks, counters and sticky error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      beat_cnt_r  <= '0;
      wait_cnt_r  <= '0;
      address     <= '0;
      write_data  <= '0;
      write       <= 1'b0;
      grant       <= '0;
      req_ack     <= '0;
      write_count <= 32'd0;
      timeout_err <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state_r)
        ST_IDLE: begin
          if (sel_valid_s) begin
            address             <= req_address[sel_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
            write_data          <= req_data[sel_idx_s*DATA_WIDTH +: DATA_WIDTH];
            write               <= 1'b1;
            grant               <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
            req_ack[sel_idx_s]  <= 1'b1;
            rr_ptr_r            <= (sel_idx_s == LAST_IDX) ? '0 : sel_idx_s + IW'(1);
            owner_r             <= sel_idx_s;
            beat_cnt_r          <= lock_s ? beat_cnt_r + BW'(1) : BW'(1);
            wait_cnt_r          <= '0;
            state_r             <= ST_WRITE;
          end else begin
            write <= 1'b0;
            grant <= '0;
          end
        end
        ST_WRITE: begin
          if (!waitrequest) begin
            write       <= 1'b0;
            grant       <= '0;
            write_count <= write_count + 32'd1;
            state_r     <= ST_IDLE;
          end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_r == WW'(TIMEOUT_CYCLES - 1))) begin
            // The word was already acked, so an abort drops it for good
            write       <= 1'b0;
            grant       <= '0;
            timeout_err <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
          end
        end
        default: begin
          write   <= 1'b0;
          grant   <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mems_onchip_write_arbiter.sv
// Directed bench: dut_a is pure round-robin (MAX_BEATS=1) and dut_b uses a 4-beat lock.
// Both use a 16-cycle timeout and share the same requester inputs.
module tb_mems_onchip_write_arbiter;
  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_address = '0;
  logic [N*32-1:0] req_data = '0;
  logic            waitrequest = 1'b0;

  logic [N-1:0] req_ack_a, grant_a, req_ack_b, grant_b;
  logic [31:0]  address_a, write_data_a, write_count_a;
  logic [31:0]  address_b, write_data_b, write_count_b;
  logic         write_a, timeout_err_a, write_b, timeout_err_b;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  mems_onchip_write_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                              .MAX_BEATS(1), .TIMEOUT_CYCLES(16)) dut_a (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_address(req_address),
    .req_data(req_data), .req_ack(req_ack_a), .grant(grant_a), .address(address_a),
    .write(write_a), .write_data(write_data_a), .waitrequest(waitrequest),
    .write_count(write_count_a), .timeout_err(timeout_err_a));

  mems_onchip_write_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                              .MAX_BEATS(4), .TIMEOUT_CYCLES(16)) dut_b (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_address(req_address),
    .req_data(req_data), .req_ack(req_ack_b), .grant(grant_b), .address(address_b),
    .write(write_b), .write_data(write_data_b), .waitrequest(waitrequest),
    .write_count(write_count_b), .timeout_err(timeout_err_b));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    req_valid   = '0;
    waitrequest = 1'b0;
    reset       = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_slots();
    for (int i = 0; i < N; i++) begin
      req_address[i*32 +: 32] = 32'h100 + 32'(i) * 32'h10;
      req_data[i*32 +: 32]    = 32'hD0 + 32'(i);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++;
    if ({write_a, grant_a, req_ack_a, timeout_err_a} !== 10'd0) begin
      bad++; $display("FAIL reset_ctrl_a: w=%0b g=%b ack=%b terr=%0b want all 0", write_a, grant_a, req_ack_a, timeout_err_a);
    end
    total++;
    if ({address_a, write_data_a, write_count_a} !== 96'd0) begin
      bad++; $display("FAIL reset_data_a: addr=%h data=%h cnt=%0d want 0", address_a, write_data_a, write_count_a);
    end
    tick();
    tick();
    total++;
    if ({write_b, grant_b, req_ack_b, timeout_err_b, write_count_b} !== 42'd0) begin
      bad++; $display("FAIL reset_held_b: w=%0b g=%b ack=%b terr=%0b cnt=%0d want 0", write_b, grant_b, req_ack_b, timeout_err_b, write_count_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    req_address[2*32 +: 32] = 32'h10;
    req_data[2*32 +: 32]    = 32'hA5;
    req_valid   = 4'b0100;
    waitrequest = 1'b0;
    tick();
    total++;
    if (write_a !== 1'b1 || address_a !== 32'h10 || write_data_a !== 32'hA5) begin
      bad++; $display("FAIL single_write: w=%0b addr=%h data=%h want 1 10 a5", write_a, address_a, write_data_a);
    end
    total++;
    if (grant_a !== 4'b0100 || req_ack_a !== 4'b0100 || write_count_a !== 32'd0) begin
      bad++; $display("FAIL single_grant: g=%b ack=%b cnt=%0d want 0100 0100 0", grant_a, req_ack_a, write_count_a);
    end
    req_valid = '0;
    tick();
    total++;
    if (write_a !== 1'b0 || grant_a !== 4'b0000 || req_ack_a !== 4'b0000 || write_count_a !== 32'd1) begin
      bad++; $display("FAIL single_done: w=%0b g=%b ack=%b cnt=%0d want 0 0000 0000 1", write_a, grant_a, req_ack_a, write_count_a);
    end
    total++;
    if (write_count_b !== 32'd1) begin
      bad++; $display("FAIL single_count_b: cnt=%0d want 1", write_count_b);
    end
  endtask

  task automatic test_stall();
    req_address[0 +: 32] = 32'h20;
    req_data[0 +: 32]    = 32'h5A;
    req_valid   = 4'b0001;
    waitrequest = 1'b1;
    tick();
    total++;
    if (write_a !== 1'b1 || grant_a !== 4'b0001 || req_ack_a !== 4'b0001) begin
      bad++; $display("FAIL stall_start: w=%0b g=%b ack=%b want 1 0001 0001", write_a, grant_a, req_ack_a);
    end
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (write_a !== 1'b1 || address_a !== 32'h20 || write_data_a !== 32'h5A ||
          req_ack_a !== 4'b0000 || write_count_a !== 32'd1) begin
        bad++; $display("FAIL stall_hold[%0d]: w=%0b addr=%h data=%h ack=%b cnt=%0d want 1 20 5a 0000 1",
                        k, write_a, address_a, write_data_a, req_ack_a, write_count_a);
      end
    end
    waitrequest = 1'b0;
    tick();
    total++;
    if (write_a !== 1'b0 || write_count_a !== 32'd2) begin
      bad++; $display("FAIL stall_release: w=%0b cnt=%0d want 0 2", write_a, write_count_a);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] seq_a [8];
    logic [N-1:0] seq_b [8];
    int ack_cnt [N];
    int na;
    int nb;
    logic prev_a;
    logic prev_b;
    int exp_b [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    do_reset();
    load_slots();
    na = 0; nb = 0; prev_a = 1'b0; prev_b = 1'b0;
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    req_valid = 4'b1111;
    for (int c = 0; c < 40 && na < 8; c++) begin
      tick();
      if (write_a && !prev_a) begin seq_a[na] = grant_a; na++; end
      if (write_b && !prev_b && nb < 8) begin seq_b[nb] = grant_b; nb++; end
      for (int i = 0; i < N; i++) if (req_ack_a[i]) ack_cnt[i]++;
      prev_a = write_a;
      prev_b = write_b;
    end
    total++;
    if (na != 8 || nb != 8) begin
      bad++; $display("FAIL fair_count: writes_a=%0d writes_b=%0d want 8 8", na, nb);
    end else begin
      for (int k = 0; k < 8; k++) begin
        total++;
        if (seq_a[k] !== (4'b0001 << (k % 4))) begin
          bad++; $display("FAIL fair_order_a[%0d]: grant=%b want %b", k, seq_a[k], 4'b0001 << (k % 4));
        end
        total++;
        if (seq_b[k] !== (4'b0001 << exp_b[k])) begin
          bad++; $display("FAIL fair_order_b[%0d]: grant=%b want %b", k, seq_b[k], 4'b0001 << exp_b[k]);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (ack_cnt[i] != 2) begin
        bad++; $display("FAIL fair_acks[%0d]: acks=%0d want 2", i, ack_cnt[i]);
      end
    end
    req_valid = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_burst_lock();
    logic [N-1:0] seq_a [9];
    logic [N-1:0] seq_b [9];
    int na;
    int nb;
    logic prev_a;
    logic prev_b;
    int exp_b [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    do_reset();
    load_slots();
    na = 0; nb = 0; prev_a = 1'b0; prev_b = 1'b0;
    req_valid = 4'b0011;
    for (int c = 0; c < 40 && nb < 9; c++) begin
      tick();
      if (write_a && !prev_a && na < 9) begin seq_a[na] = grant_a; na++; end
      if (write_b && !prev_b) begin seq_b[nb] = grant_b; nb++; end
      prev_a = write_a;
      prev_b = write_b;
    end
    total++;
    if (na != 9 || nb != 9) begin
      bad++; $display("FAIL lock_count: writes_a=%0d writes_b=%0d want 9 9", na, nb);
    end else begin
      for (int k = 0; k < 9; k++) begin
        total++;
        if (seq_b[k] !== (4'b0001 << exp_b[k])) begin
          bad++; $display("FAIL lock_order_b[%0d]: grant=%b want %b", k, seq_b[k], 4'b0001 << exp_b[k]);
        end
        total++;
        if (seq_a[k] !== (4'b0001 << (k % 2))) begin
          bad++; $display("FAIL lock_order_a[%0d]: grant=%b want %b", k, seq_a[k], 4'b0001 << (k % 2));
        end
      end
    end
    req_valid = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req_address[2*32 +: 32] = 32'h30;
    req_data[2*32 +: 32]    = 32'h33;
    req_valid   = 4'b0100;
    waitrequest = 1'b1;
    tick();
    total++;
    if (write_a !== 1'b1 || grant_a !== 4'b0100) begin
      bad++; $display("FAIL timeout_start: w=%0b g=%b want 1 0100", write_a, grant_a);
    end
    req_valid = '0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      total++;
      if (write_a !== 1'b1 || timeout_err_a !== 1'b0) begin
        bad++; $display("FAIL timeout_stall[%0d]: w=%0b terr=%0b want 1 0", k, write_a, timeout_err_a);
      end
    end
    tick();
    total++;
    if (write_a !== 1'b0 || grant_a !== 4'b0000 || timeout_err_a !== 1'b1 || write_count_a !== 32'd0) begin
      bad++; $display("FAIL timeout_abort: w=%0b g=%b terr=%0b cnt=%0d want 0 0000 1 0", write_a, grant_a, timeout_err_a, write_count_a);
    end
    total++;
    if (write_b !== 1'b0 || timeout_err_b !== 1'b1) begin
      bad++; $display("FAIL timeout_abort_b: w=%0b terr=%0b want 0 1", write_b, timeout_err_b);
    end
    tick(); tick();
    req_address[1*32 +: 32] = 32'h40;
    req_data[1*32 +: 32]    = 32'h44;
    req_valid   = 4'b0010;
    waitrequest = 1'b0;
    tick();
    total++;
    if (write_a !== 1'b1 || grant_a !== 4'b0010 || address_a !== 32'h40 || write_data_a !== 32'h44) begin
      bad++; $display("FAIL timeout_next: w=%0b g=%b addr=%h data=%h want 1 0010 40 44", write_a, grant_a, address_a, write_data_a);
    end
    req_valid = '0;
    tick();
    total++;
    if (write_a !== 1'b0 || write_count_a !== 32'd1 || timeout_err_a !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky: w=%0b cnt=%0d terr=%0b want 0 1 1", write_a, write_count_a, timeout_err_a);
    end
  endtask

  task automatic test_reset_mid_write();
    req_address[3*32 +: 32] = 32'h50;
    req_data[3*32 +: 32]    = 32'h55;
    req_valid   = 4'b1000;
    waitrequest = 1'b1;
    tick();
    total++;
    if (write_a !== 1'b1 || grant_a !== 4'b1000) begin
      bad++; $display("FAIL midrst_start: w=%0b g=%b want 1 1000", write_a, grant_a);
    end
    req_valid = '0;
    tick();
    #3 reset = 1'b1;
    #1;
    total++;
    if (write_a !== 1'b0 || grant_a !== 4'b0000 || timeout_err_a !== 1'b0 || write_count_a !== 32'd0) begin
      bad++; $display("FAIL midrst_async_a: w=%0b g=%b terr=%0b cnt=%0d want 0 0000 0 0", write_a, grant_a, timeout_err_a, write_count_a);
    end
    total++;
    if (write_b !== 1'b0 || grant_b !== 4'b0000 || timeout_err_b !== 1'b0 || write_count_b !== 32'd0) begin
      bad++; $display("FAIL midrst_async_b: w=%0b g=%b terr=%0b cnt=%0d want 0 0000 0 0", write_b, grant_b, timeout_err_b, write_count_b);
    end
    load_slots();
    req_valid   = 4'b1111;
    waitrequest = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (write_a !== 1'b1 || grant_a !== 4'b0001 || grant_b !== 4'b0001 || address_a !== 32'h100) begin
      bad++; $display("FAIL midrst_first_grant: w=%0b ga=%b gb=%b addr=%h want 1 0001 0001 100", write_a, grant_a, grant_b, address_a);
    end
    req_valid = '0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_fairness();
    test_burst_lock();
    test_timeout();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mems_onchip_write_arbiter.md
Name: mems_onchip_write_arbiter

Overview:
- Round-robin arbiter sharing the single Avalon-MM write master port into on-chip memory between NUM_REQ write requesters (e.g. MEMS sensor channels, pattern generator).
- Captures one address/data word per grant and drives the Avalon write handshake, honouring waitrequest.
- Supports bounded burst locking and a waitrequest timeout.
- Sits between the requester blocks and the on-chip memory slave.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, Avalon address width.
- DATA_WIDTH, 32, Avalon write data width.
- MAX_BEATS, 4, max consecutive grants to one requester while its req_valid stays high (1 = pure round-robin).
- TIMEOUT_CYCLES, 1024, waitrequest cycles before abort (0 = never abort).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a word pending.
- req_address  in  NUM_REQ*ADDR_WIDTH  flattened; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  flattened, same slicing.
- req_ack  out  NUM_REQ  one-cycle pulse: word from requester i captured.
- grant  out  NUM_REQ  one-hot owner of the transaction in flight; 0 when idle.
- address  out  ADDR_WIDTH  Avalon address.
- write  out  1  Avalon write strobe.
- write_data  out  DATA_WIDTH  Avalon write data.
- waitrequest  in  1  Avalon slave stall.
- write_count  out  32  completed writes; wraps 0xFFFFFFFF -> 0.
- timeout_err  out  1  sticky; set on any timeout abort.

Behaviour:
- Reset (async, any cycle including mid-transfer):
  - address, write_data, write_count = 0; write, req_ack, grant = 0; timeout_err = 0.
  - rr_ptr = 0, beat_cnt = 0, state = IDLE.
  - An in-flight write is dropped, with no ack or count.
- All outputs are registered. req_ack defaults to 0 every cycle.
- States: IDLE, WRITE.
- IDLE, no req_valid bit set: remain in IDLE; write = 0, grant = 0.
- IDLE, requester selection:
  - Lock: if last owner L has req_valid[L]=1 and beat_cnt < MAX_BEATS, select L and increment beat_cnt.
  - Otherwise: select the first set bit scanning from rr_ptr upward modulo NUM_REQ, and set beat_cnt = 1.
- IDLE, on selecting requester i (same edge):
  - Capture address/write_data from slice i.
  - write <= 1, grant <= one-hot(i), req_ack[i] <= 1, rr_ptr <= (i+1) mod NUM_REQ, state <= WRITE.
  - Latency: req_valid high at edge t -> write and req_ack high in cycle after t.
- Requester contract:
  - On seeing req_ack, update or drop valid/address/data at the next edge.
  - Captured data is independent of later requester changes.
- WRITE:
  - address, write_data and write held stable while waitrequest = 1.
  - Edge with waitrequest = 0: write accepted. write <= 0, grant <= 0, write_count += 1, state <= IDLE.
- Minimum one idle cycle (write = 0) between transactions; peak throughput 1 write per 2 cycles.
- Timeout:
  - wait_cnt counts WRITE cycles with waitrequest = 1.
  - If TIMEOUT_CYCLES != 0 and wait_cnt reaches TIMEOUT_CYCLES: write <= 0, grant <= 0, timeout_err <= 1, state <= IDLE.
  - No count increment; the aborted word is not retried (it was already acked).
  - wait_cnt clears on entry to WRITE.
- Lock release: beat_cnt expires or owner drops req_valid -> next grant moves to the next requester by round-robin. Starvation bound is (NUM_REQ-1)*MAX_BEATS transactions.
- Simultaneous requests: resolved purely by rr_ptr order; ties are impossible.
- req_valid changes while in WRITE: ignored until IDLE.

Test Plan:
- Single requester: req_valid[2]=1, addr 0x10, data 0xA5, waitrequest=0. Expect:
  - write high exactly one cycle after capture edge, with address=0x10, write_data=0xA5.
  - req_ack[2] pulses once, grant=0b0100, write_count=1.
- Stall hold: waitrequest=1 for 5 cycles. Expect write/address/data stable for 6 cycles, one ack, count increments only after waitrequest=0.
- Fairness, MAX_BEATS=1: all 4 requesters continuously valid, 8 writes. Expect grant order 0,1,2,3,0,1,2,3 and each requester acked twice.
- Burst lock, MAX_BEATS=4: requesters 0 and 1 continuously valid. Expect grant order 0,0,0,0,1,1,1,1,0...
- Timeout, TIMEOUT_CYCLES=16: waitrequest held 1. Expect:
  - write drops after 16 stall cycles, timeout_err=1 and stays set, write_count unchanged.
  - Next request is serviced normally.
- Reset mid-WRITE: assert reset during stall. Expect write, grant, timeout_err = 0 and write_count = 0 immediately (asynchronously), and the first grant after release goes to requester 0.
